// File: rtl/ro_puf_engine.sv
// rtl/ro_puf_engine.sv - ring-oscillator PUF measurement engine
//
// Purpose:
//   Enables one pair of external ring oscillators at a time, counts the
//   synchronised rising edges of each over a fixed window of clk cycles and
//   builds a RESP_BITS-wide response, one pair comparison per bit. The
//   challenge selects the base oscillator index. Requests use a
//   start/busy/valid handshake.
//
// Optional feature:
//   PUF_RAW_COUNT_EN - when defined, adds raw_cnt_a/raw_cnt_b outputs that
//   latch the two pair counts at every comparison.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   osc_in     in   [N_OSC]   asynchronous oscillator outputs
//   osc_en     out  [N_OSC]   oscillator enables, only the current pair set
//   challenge  in   [log2 N]  base oscillator index, sampled on accepted start
//   start      in   request a response (accepted only while idle)
//   busy       out  measurement in progress
//   response   out  [RESP_BITS] last completed response
//   valid      out  one-cycle pulse when response updates
//   tie        out  some pair of the last response compared equal
//   sat        out  some counter of the last response saturated
//   raw_cnt_a  out  [COUNT_W] count of oscillator A at the last comparison (option)
//   raw_cnt_b  out  [COUNT_W] count of oscillator B at the last comparison (option)

module ro_puf_engine #(
  parameter int N_OSC      = 16,
  parameter int COUNT_W    = 16,
  parameter int WINDOW_CYC = 1024,
  parameter int SETTLE_CYC = 8,
  parameter int RESP_BITS  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_OSC-1:0]           osc_in,
  output logic [N_OSC-1:0]           osc_en,
  input  logic [$clog2(N_OSC)-1:0]   challenge,
  input  logic                       start,
  output logic                       busy,
  output logic [RESP_BITS-1:0]       response,
  output logic                       valid,
  output logic                       tie,
  output logic                       sat
`ifdef PUF_RAW_COUNT_EN
  ,
  output logic [COUNT_W-1:0]         raw_cnt_a,
  output logic [COUNT_W-1:0]         raw_cnt_b
`endif
);

  localparam int IDX_W   = $clog2(N_OSC);
  localparam int K_W     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TMR_MAX = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_W-1:0] CNT_NEAR = CNT_MAX - COUNT_W'(1);
  localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]   COUNT_LAST  = TMR_W'(WINDOW_CYC - 1);
  localparam logic [K_W-1:0]     K_LAST      = K_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [N_OSC-1:0]     sync1_q, sync2_q, sync3_q;
  logic [N_OSC-1:0]     rise;
  logic [IDX_W-1:0]     ch_q;
  logic [K_W-1:0]       k_q;
  logic [TMR_W-1:0]     tmr_q;
  logic [COUNT_W-1:0]   cnt_a_q, cnt_b_q;
  logic [RESP_BITS-1:0] shadow_q, shadow_next;
  logic [RESP_BITS-1:0] response_q;
  logic                 tie_acc_q, sat_acc_q;
  logic                 tie_q, sat_q;
  logic [IDX_W-1:0]     idx_a, idx_b;
  logic                 rise_a, rise_b;
  logic                 cnt_gt, cnt_eq;
  logic                 settle_last, count_last, k_last;

  // Free-running two-flop synchroniser plus one edge-detect stage per line.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  // Pair k uses oscillators ch+2k and ch+2k+1; N_OSC is a power of two so
  // truncation to IDX_W bits gives the modulo wrap for free.
  always_comb begin
    idx_a  = ch_q + (IDX_W'(k_q) << 1);
    idx_b  = idx_a + IDX_W'(1);
    rise_a = rise[idx_a];
    rise_b = rise[idx_b];
  end

  always_comb begin
    cnt_gt      = (cnt_a_q > cnt_b_q);
    cnt_eq      = (cnt_a_q == cnt_b_q);
    settle_last = (tmr_q == SETTLE_LAST);
    count_last  = (tmr_q == COUNT_LAST);
    k_last      = (k_q == K_LAST);
    shadow_next        = shadow_q;
    shadow_next[k_q]   = cnt_gt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    valid   = 1'b0;
    osc_en  = '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        osc_en = (N_OSC'(1) << idx_a) | (N_OSC'(1) << idx_b);
        if (settle_last) begin
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        osc_en = (N_OSC'(1) << idx_a) | (N_OSC'(1) << idx_b);
        if (count_last) begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        state_d = k_last ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        valid   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath. The published response/tie/sat load on the COMPARE -> DONE
  // edge so they are already updated in the cycle valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q       <= '0;
      k_q        <= '0;
      tmr_q      <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      shadow_q   <= '0;
      response_q <= '0;
      tie_acc_q  <= 1'b0;
      sat_acc_q  <= 1'b0;
      tie_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tmr_q <= '0;
          if (start) begin
            ch_q      <= challenge;
            k_q       <= '0;
            tie_acc_q <= 1'b0;
            sat_acc_q <= 1'b0;
            shadow_q  <= '0;
          end
        end
        S_SETTLE: begin
          cnt_a_q <= '0;
          cnt_b_q <= '0;
          tmr_q   <= settle_last ? '0 : tmr_q + TMR_W'(1);
        end
        S_COUNT: begin
          tmr_q <= count_last ? '0 : tmr_q + TMR_W'(1);
          if (rise_a && (cnt_a_q != CNT_MAX)) begin
            cnt_a_q <= cnt_a_q + COUNT_W'(1);
            if (cnt_a_q == CNT_NEAR) begin
              sat_acc_q <= 1'b1;
            end
          end
          if (rise_b && (cnt_b_q != CNT_MAX)) begin
            cnt_b_q <= cnt_b_q + COUNT_W'(1);
            if (cnt_b_q == CNT_NEAR) begin
              sat_acc_q <= 1'b1;
            end
          end
        end
        S_COMPARE: begin
          shadow_q <= shadow_next;
          if (cnt_eq) begin
            tie_acc_q <= 1'b1;
          end
          if (k_last) begin
            response_q <= shadow_next;
            tie_q      <= tie_acc_q | cnt_eq;
            sat_q      <= sat_acc_q;
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PUF_RAW_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_cnt_a <= '0;
      raw_cnt_b <= '0;
    end else if (state_q == S_COMPARE) begin
      raw_cnt_a <= cnt_a_q;
      raw_cnt_b <= cnt_b_q;
    end
  end
`endif

  assign response = response_q;
  assign tie      = tie_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_ro_puf_engine.sv
// tb/tb_ro_puf_engine.sv - self-checking bench for ro_puf_engine

module tb_ro_puf_engine;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int S  = 3;
  localparam int R  = 4;
  localparam int P  = S + W + 1;
  localparam int L  = 1 + R * P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] challenge = 2'd0;

  logic [3:0] osc_in8 = '0, osc_in3 = '0;
  logic [3:0] osc_en8, osc_en3;
  logic       busy8, busy3, valid8, valid3, tie8, tie3, sat8, sat3;
  logic [3:0] resp8, resp3;
`ifdef PUF_RAW_COUNT_EN
  logic [7:0] ra8, rb8;
  logic [2:0] ra3, rb3;
`endif

  int period[4] = '{4, 8, 6, 16};
  int ptab[4]   = '{4, 6, 8, 16};
  int ph8[4]    = '{0, 0, 0, 0};
  int ph3[4]    = '{0, 0, 0, 0};

  int total = 0;
  int bad   = 0;

  ro_puf_engine #(.N_OSC(N), .COUNT_W(8), .WINDOW_CYC(W), .SETTLE_CYC(S), .RESP_BITS(R)) dut8 (
    .clk(clk), .reset(reset), .osc_in(osc_in8), .osc_en(osc_en8), .challenge(challenge),
    .start(start), .busy(busy8), .response(resp8), .valid(valid8), .tie(tie8), .sat(sat8)
`ifdef PUF_RAW_COUNT_EN
    , .raw_cnt_a(ra8), .raw_cnt_b(rb8)
`endif
  );

  ro_puf_engine #(.N_OSC(N), .COUNT_W(3), .WINDOW_CYC(W), .SETTLE_CYC(S), .RESP_BITS(R)) dut3 (
    .clk(clk), .reset(reset), .osc_in(osc_in3), .osc_en(osc_en3), .challenge(challenge),
    .start(start), .busy(busy3), .response(resp3), .valid(valid3), .tie(tie3), .sat(sat3)
`ifdef PUF_RAW_COUNT_EN
    , .raw_cnt_a(ra3), .raw_cnt_b(rb3)
`endif
  );

  // Gated oscillators: held low while disabled, start low when enabled.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!osc_en8[i]) begin
        ph8[i]     <= 0;
        osc_in8[i] <= 1'b0;
      end else begin
        ph8[i]     <= (ph8[i] + 1) % period[i];
        osc_in8[i] <= (((ph8[i] + 1) % period[i]) >= period[i] / 2);
      end
      if (!osc_en3[i]) begin
        ph3[i]     <= 0;
        osc_in3[i] <= 1'b0;
      end else begin
        ph3[i]     <= (ph3[i] + 1) % period[i];
        osc_in3[i] <= (((ph3[i] + 1) % period[i]) >= period[i] / 2);
      end
    end
  end

  // Expected result from oscillator periods alone: nominal edge count is
  // window/period clamped to the counter maximum; the chosen periods keep
  // distinct nominal counts at least two apart so phase jitter cannot flip a bit.
  function automatic void predict(input int ch, input int cmax,
                                  output logic [3:0] r, output logic t, output logic s);
    int a, b, na, nb;
    r = '0; t = 1'b0; s = 1'b0;
    for (int k = 0; k < R; k++) begin
      a  = (ch + 2 * k) % N;
      b  = (a + 1) % N;
      na = W / period[a]; if (na > cmax) na = cmax;
      nb = W / period[b]; if (nb > cmax) nb = cmax;
      r[k] = (na > nb);
      if (na == nb) t = 1'b1;
      if (na >= cmax || nb >= cmax) s = 1'b1;
    end
  endfunction

  function automatic int exp_en(input int m, input int ch);
    int s, k, a, b;
    if (m < 1 || m >= L) return 0;
    s = (m - 1) % P;
    k = (m - 1) / P;
    if (s >= S + W) return 0;
    a = (ch + 2 * k) % N;
    b = (a + 1) % N;
    return (1 << a) | (1 << b);
  endfunction

  // Model: mt = cycles since start was accepted (0 = idle).
  int         mt[2]     = '{0, 0};
  int         m_ch[2]   = '{0, 0};
  logic [3:0] m_resp[2] = '{4'd0, 4'd0};
  logic       m_tie[2]  = '{1'b0, 1'b0};
  logic       m_sat[2]  = '{1'b0, 1'b0};
  logic [3:0] p_resp[2] = '{4'd0, 4'd0};
  logic       p_tie[2]  = '{1'b0, 1'b0};
  logic       p_sat[2]  = '{1'b0, 1'b0};

  always @(posedge clk) begin
    logic [3:0] r;
    logic       t, s;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mt[d]     <= 0;
        m_resp[d] <= '0;
        m_tie[d]  <= 1'b0;
        m_sat[d]  <= 1'b0;
      end else if (mt[d] == 0) begin
        if (start) begin
          predict(int'(challenge), (d == 0) ? 255 : 7, r, t, s);
          mt[d]     <= 1;
          m_ch[d]   <= int'(challenge);
          p_resp[d] <= r;
          p_tie[d]  <= t;
          p_sat[d]  <= s;
        end
      end else begin
        mt[d] <= (mt[d] == L) ? 0 : mt[d] + 1;
        if (mt[d] == L - 1) begin
          m_resp[d] <= p_resp[d];
          m_tie[d]  <= p_tie[d];
          m_sat[d]  <= p_sat[d];
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy8",  int'(busy8),   int'(mt[0] >= 1));
    chk("valid8", int'(valid8),  int'(mt[0] == L));
    chk("en8",    int'(osc_en8), exp_en(mt[0], m_ch[0]));
    chk("resp8",  int'(resp8),   int'(m_resp[0]));
    chk("tie8",   int'(tie8),    int'(m_tie[0]));
    chk("sat8",   int'(sat8),    int'(m_sat[0]));
    chk("busy3",  int'(busy3),   int'(mt[1] >= 1));
    chk("valid3", int'(valid3),  int'(mt[1] == L));
    chk("en3",    int'(osc_en3), exp_en(mt[1], m_ch[1]));
    chk("resp3",  int'(resp3),   int'(m_resp[1]));
    chk("tie3",   int'(tie3),    int'(m_tie[1]));
    chk("sat3",   int'(sat3),    int'(m_sat[1]));
`ifdef PUF_RAW_COUNT_EN
    if (mt[0] == L) begin
      chk("raw_a_near", int'((int'(ra8) - W / period[(m_ch[0] + 6) % N]) inside {[-1:1]}), 1);
      chk("raw_b_near", int'((int'(rb8) - W / period[(m_ch[0] + 7) % N]) inside {[-1:1]}), 1);
    end
`endif
  end

  // Called at a negedge; returns cycles from acceptance to valid.
  task automatic run(input int ch, output int lat);
    int g;
    g = 0;
    while ((busy8 || valid8) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    start     = 1'b1;
    challenge = ch[1:0];
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!valid8 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("valid_seen", int'(valid8), 1);
  endtask

  initial begin
    int lat, gap, t0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", int'(busy8), 0);
    chk("rst_en",   int'(osc_en8), 0);
    chk("rst_resp", int'(resp8), 0);

    // Default periods, challenge 0.
    run(0, lat);
    chk("latency", lat, 273);
    chk("c0_resp8", int'(resp8), 4'b1111);
    chk("c0_tie8",  int'(tie8), 0);
    chk("c0_sat8",  int'(sat8), 0);
    chk("c0_resp3", int'(resp3), 4'b1010);
    chk("c0_tie3",  int'(tie3), 1);
    chk("c0_sat3",  int'(sat3), 1);

    run(1, lat);
    chk("c1_resp8", int'(resp8), 4'b0000);

    period[1] = 4;
    run(0, lat);
    chk("eq_resp8", int'(resp8), 4'b1010);
    chk("eq_tie8",  int'(tie8), 1);
    period[1] = 8;

    // Reset in the middle of a measurement.
    start = 1'b1; challenge = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy8), 0);
    chk("abort_en",   int'(osc_en8), 0);
    chk("abort_resp", int'(resp8), 0);
    run(2, lat);
    chk("c2_resp8", int'(resp8), 4'b1111);

    // Start held high: back-to-back responses.
    start = 1'b1; challenge = 2'd0;
    t0 = 0;
    while (!valid8 && t0 < 600) begin @(negedge clk); t0++; end
    chk("b2b_first", int'(valid8), 1);
    @(negedge clk);
    t0 = 1;
    while (!valid8 && t0 < 600) begin @(negedge clk); t0++; end
    chk("b2b_interval", t0, 274);
    start = 1'b0;

    // Randomised periods, challenges and idle gaps.
    for (int it = 0; it < 10; it++) begin
      @(negedge clk);
      while (busy8) @(negedge clk);
      for (int i = 0; i < N; i++) period[i] = ptab[$urandom_range(0, 3)];
      gap = $urandom_range(0, 4);
      repeat (gap) @(negedge clk);
      run(int'($urandom_range(0, 3)), lat);
      chk("rnd_latency", lat, L);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
